// File: rtl/mem_access_pkg.sv
//------------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the memory access unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Collapse every request onto one of the legal widths; anything unlisted is a word access.
  function automatic logic [2:0] norm_funct3(input logic ifetch, input logic write,
                                             input logic [2:0] f3);
    logic [2:0] r;
    r = F3_W;
    if (!ifetch) begin
      if (write) begin
        if (f3 == F3_B || f3 == F3_H) r = f3;
      end else begin
        if (f3 == F3_B || f3 == F3_H || f3 == F3_BU || f3 == F3_HU) r = f3;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
//------------------------------------------------------------------------------
// mem_lane_align
// Combinational load lane extract/extend and store lane merge.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rbuf_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ext_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rbuf_i[7:0];
    case (lane_i)
      2'd1:    w_byte = rbuf_i[15:8];
      2'd2:    w_byte = rbuf_i[23:16];
      2'd3:    w_byte = rbuf_i[31:24];
      default: w_byte = rbuf_i[7:0];
    endcase
    w_half = lane_i[1] ? rbuf_i[31:16] : rbuf_i[15:0];
  end

  always_comb begin
    ext_data_o = rbuf_i;
    case (funct3_i)
      F3_B:    ext_data_o = {{24{w_byte[7]}}, w_byte};
      F3_BU:   ext_data_o = {24'h0, w_byte};
      F3_H:    ext_data_o = {{16{w_half[15]}}, w_half};
      F3_HU:   ext_data_o = {16'h0, w_half};
      default: ext_data_o = rbuf_i;
    endcase
  end

  always_comb begin
    merged_o = rbuf_i;
    case (funct3_i)
      F3_B: begin
        case (lane_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// mem_access_unit
// Sequences IR fetches, loads and stores (RMW for sb/sh) to a unified memory.
// Optional feature macro: MISALIGN_TRAP_EN (trap instead of clearing low bits).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] RESET_IR  = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_ifetch_i,
  input  logic        req_write_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        done_o,
  output logic        misaligned_o,
  output logic [31:0] ir_o,
  output logic [31:0] mdr_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1) & 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic        ifetch_q, write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, rbuf_q, ir_q, mdr_q;

  logic        w_accept, w_store, w_is_half, w_is_word;
  logic [2:0]  w_f3n;
  logic [31:0] w_addr_eff, w_align_word, w_ext, w_merged;

  assign w_accept  = req_valid_i && (state_q == IDLE);
  assign w_store   = req_write_i && !req_ifetch_i;
  assign w_f3n     = norm_funct3(req_ifetch_i, req_write_i, req_funct3_i);
  assign w_is_half = (w_f3n == F3_H) || (w_f3n == F3_HU);
  assign w_is_word = (w_f3n == F3_W);

`ifdef MISALIGN_TRAP_EN
  logic misal_q;
  logic w_misal;
  assign w_misal    = (w_is_half && req_addr_i[0]) || (w_is_word && (req_addr_i[1:0] != 2'b00));
  assign w_addr_eff = req_addr_i;
`else
  // Offending low bits are silently cleared so the access stays naturally aligned.
  assign w_addr_eff = {req_addr_i[31:2],
                       w_is_word ? 1'b0 : req_addr_i[1],
                       (w_is_word || w_is_half) ? 1'b0 : req_addr_i[0]};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
`ifdef MISALIGN_TRAP_EN
          if (w_misal)                          state_d = RESP;
          else if (w_store && w_f3n == F3_W)    state_d = WR;
          else                                  state_d = RD;
`else
          if (w_store && w_f3n == F3_W) state_d = WR;
          else                          state_d = RD;
`endif
        end
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ifetch_q <= 1'b0;
      write_q  <= 1'b0;
      funct3_q <= F3_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      ir_q     <= RESET_IR;
      mdr_q    <= '0;
`ifdef MISALIGN_TRAP_EN
      misal_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        ifetch_q <= req_ifetch_i;
        write_q  <= w_store;
        funct3_q <= w_f3n;
        addr_q   <= w_addr_eff;
        wdata_q  <= req_wdata_i;
`ifdef MISALIGN_TRAP_EN
        misal_q  <= w_misal;
`endif
      end
      if (state_q == RD) begin
        rbuf_q <= mem_data_i;
        if (!write_q) begin
          if (ifetch_q) ir_q  <= mem_data_i;
          else          mdr_q <= w_ext;
        end
      end
    end
  end

  // Loads extract straight from the memory bus in RD; RMW merges use the buffered word in WR.
  assign w_align_word = (state_q == RD) ? mem_data_i : rbuf_q;

  mem_lane_align u_lane_align (
    .rbuf_i     (w_align_word),
    .wdata_i    (wdata_q),
    .lane_i     (addr_q[1:0]),
    .funct3_i   (funct3_q),
    .ext_data_o (w_ext),
    .merged_o   (w_merged)
  );

  assign req_ready_o      = (state_q == IDLE);
  assign done_o           = (state_q == RESP);
  assign mem_read_o       = (state_q == RD);
  assign mem_write_o      = (state_q == WR);
  assign mem_address_o    = addr_q & ADDR_MASK;
  assign mem_write_data_o = (funct3_q == F3_W) ? wdata_q : w_merged;
  assign ir_o             = ir_q;
  assign mdr_o            = mdr_q;

`ifdef MISALIGN_TRAP_EN
  assign misaligned_o = (state_q == RESP) && misal_q;
`else
  assign misaligned_o = 1'b0;
`endif

endmodule

`default_nettype wire
